// File: rtl/sd_pkg.sv
// sd_pkg: shared types and constants for the SPI-mode SD command controller.
//   - sd_state_t : controller state encoding
//   - req_id_t   : requester identifier latched at grant
//   - command index constants, fixed CRC bytes, CRC7 polynomial
//   - helpers: crc_const() (fixed CRC byte per command),
//              is_long_resp() (commands answered with a 40-bit R3/R7)
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_R,
    ST_RESP,
    ST_TAIL,
    ST_DONE
  } sd_state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_INIT,
    REQ_WR,
    REQ_RD
  } req_id_t;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD24  = 6'd24;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD58  = 6'd58;

  localparam logic [7:0] CRC_CMD0    = 8'h95;
  localparam logic [7:0] CRC_CMD8    = 8'h87;
  localparam logic [7:0] CRC_DEFAULT = 8'hFF;

  // x^7 + x^3 + 1, top term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int unsigned FRAME_BITS = 48;
  localparam int unsigned CRC_BITS   = 40;
  localparam int unsigned TAIL_BITS  = 8;
  localparam int unsigned R1_REST    = 7;
  localparam int unsigned R7_REST    = 39;

  function automatic logic [7:0] crc_const(input logic [5:0] cmd);
    logic [7:0] c;
    c = CRC_DEFAULT;
    if (cmd == CMD0) c = CRC_CMD0;
    if (cmd == CMD8) c = CRC_CMD8;
    return c;
  endfunction

  function automatic logic is_long_resp(input logic [5:0] cmd);
    return (cmd == CMD8) || (cmd == CMD58);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1) generator, MSB-first input.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : consume din this cycle
//   clr      : synchronous clear (wins over en)
//   din      : serial data bit
//   crc      : current 7-bit remainder
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_ctrl.sv
// sd_cmd_ctrl: SPI-mode SD command controller. Arbitrates init/write/read
// sequencers (fixed priority init > wr > rd; wr/rd gated by init_done),
// frames each request as {01, cmd, arg, crc7, 1}, shifts it out in SPI
// mode 0, polls MISO for the response start bit, captures R1 or R3/R7,
// sends 8 trailing clocks and pulses the matching ack.
// Parameters: CLK_DIV (clk per SCLK half-period), NCR_MAX (poll bytes).
// Ports:
//   clk, rst                      : clock, async active-high reset
//   init/wr/rd_req, _cmd, _arg    : request, command index, argument
//   init_done                     : enables wr/rd requesters
//   init/wr/rd_ack                : one-cycle completion pulse
//   resp, resp_to                 : captured response (right-aligned), timeout
//   busy                          : transaction in progress
//   sd_sclk, sd_cs_n, sd_mosi, sd_miso : SD pads
// Build option: define SD_CRC7_EN to compute crc7 serially; otherwise a
// fixed CRC byte per command is used.
module sd_cmd_ctrl
  import sd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned NCR_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [5:0]  init_cmd,
  input  logic [5:0]  wr_cmd,
  input  logic [5:0]  rd_cmd,
  input  logic [31:0] init_arg,
  input  logic [31:0] wr_arg,
  input  logic [31:0] rd_arg,
  input  logic        init_done,
  output logic        init_ack,
  output logic        wr_ack,
  output logic        rd_ack,
  output logic [39:0] resp,
  output logic        resp_to,
  output logic        busy,
  output logic        sd_sclk,
  output logic        sd_cs_n,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] POLL_LAST = 16'(NCR_MAX * 8 - 1);
  localparam logic [15:0] SEND_LAST = 16'(FRAME_BITS - 1);
  localparam logic [15:0] TAIL_LAST = 16'(TAIL_BITS - 1);
  localparam logic [15:0] R1_LAST   = 16'(R1_REST - 1);
  localparam logic [15:0] R7_LAST   = 16'(R7_REST - 1);

  sd_state_t   state;
  req_id_t     req_id;
  logic [47:0] sr;
  logic [47:0] sr_next;
  logic [15:0] bit_cnt;
  logic [15:0] div_cnt;
  logic        miso_s;
  logic        long_q;
  logic [38:0] resp_sh;

  req_id_t     grant_id;
  logic [5:0]  grant_cmd;
  logic [31:0] grant_arg;
  logic [47:0] grant_frame;

  // MOSI is the shift register MSB; ones shift in behind the frame so the
  // line idles high through WAIT_R and TAIL.
  assign sd_mosi = sr[47];

  always_comb begin
    grant_id  = REQ_NONE;
    grant_cmd = '0;
    grant_arg = '0;
    if (init_req) begin
      grant_id  = REQ_INIT;
      grant_cmd = init_cmd;
      grant_arg = init_arg;
    end else if (init_done && wr_req) begin
      grant_id  = REQ_WR;
      grant_cmd = wr_cmd;
      grant_arg = wr_arg;
    end else if (init_done && rd_req) begin
      grant_id  = REQ_RD;
      grant_cmd = rd_cmd;
      grant_arg = rd_arg;
    end
`ifdef SD_CRC7_EN
    grant_frame = {2'b01, grant_cmd, grant_arg, 8'hFF};
`else
    grant_frame = {2'b01, grant_cmd, grant_arg, crc_const(grant_cmd)};
`endif
  end

`ifdef SD_CRC7_EN
  logic [6:0] crc_val;
  logic       crc_en;
  logic       crc_clr;

  // CRC consumes each of the first 40 bits on its SCLK rising edge, so the
  // remainder is settled before the falling edge that commits the CRC byte.
  assign crc_clr = (state == ST_IDLE);
  assign crc_en  = (state == ST_SEND) && (div_cnt == DIV_LAST) && !sd_sclk &&
                   (bit_cnt < 16'(CRC_BITS));

  sd_crc7 u_crc7 (
    .clk (clk),
    .rst (rst),
    .en  (crc_en),
    .clr (crc_clr),
    .din (sd_mosi),
    .crc (crc_val)
  );
`endif

  always_comb begin
    sr_next = {sr[46:0], 1'b1};
`ifdef SD_CRC7_EN
    if (bit_cnt == 16'(CRC_BITS - 1)) sr_next[47:40] = {crc_val, 1'b1};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      req_id   <= REQ_NONE;
      sr       <= '1;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      miso_s   <= 1'b1;
      long_q   <= 1'b0;
      resp_sh  <= '0;
      resp     <= '1;
      resp_to  <= 1'b0;
      busy     <= 1'b0;
      sd_sclk  <= 1'b0;
      sd_cs_n  <= 1'b1;
      init_ack <= 1'b0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
    end else begin
      init_ack <= 1'b0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_id != REQ_NONE) begin
            state   <= ST_SEND;
            req_id  <= grant_id;
            long_q  <= is_long_resp(grant_cmd);
            sr      <= grant_frame;
            sd_cs_n <= 1'b0;
            sd_sclk <= 1'b0;
            busy    <= 1'b1;
            resp_to <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            resp_sh <= '0;
          end
        end
        ST_DONE: begin
          case (req_id)
            REQ_INIT: init_ack <= 1'b1;
            REQ_WR:   wr_ack   <= 1'b1;
            REQ_RD:   rd_ack   <= 1'b1;
            default:  ;
          endcase
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          // Bit engine: low half then high half; MISO sampled on the rising
          // edge, all bit-level decisions taken on the falling edge.
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt <= '0;
            if (!sd_sclk) begin
              sd_sclk <= 1'b1;
              miso_s  <= sd_miso;
            end else begin
              sd_sclk <= 1'b0;
              case (state)
                ST_SEND: begin
                  sr <= sr_next;
                  if (bit_cnt == SEND_LAST) begin
                    state   <= ST_WAIT_R;
                    bit_cnt <= '0;
                  end else begin
                    bit_cnt <= bit_cnt + 16'd1;
                  end
                end
                ST_WAIT_R: begin
                  if (!miso_s) begin
                    // start bit is the response MSB; resp_sh was cleared at grant
                    state   <= ST_RESP;
                    bit_cnt <= '0;
                  end else if (bit_cnt == POLL_LAST) begin
                    state   <= ST_TAIL;
                    resp_to <= 1'b1;
                    resp    <= '1;
                    bit_cnt <= '0;
                  end else begin
                    bit_cnt <= bit_cnt + 16'd1;
                  end
                end
                ST_RESP: begin
                  resp_sh <= {resp_sh[37:0], miso_s};
                  if (bit_cnt == (long_q ? R7_LAST : R1_LAST)) begin
                    resp    <= {resp_sh, miso_s};
                    state   <= ST_TAIL;
                    bit_cnt <= '0;
                  end else begin
                    bit_cnt <= bit_cnt + 16'd1;
                  end
                end
                ST_TAIL: begin
                  if (bit_cnt == TAIL_LAST) begin
                    state   <= ST_DONE;
                    sd_cs_n <= 1'b1;
                  end else begin
                    bit_cnt <= bit_cnt + 16'd1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// tb_sd_cmd_ctrl: self-checking bench for sd_cmd_ctrl with a behavioural
// SD card on the pad side (captures the 48-bit frame, answers after a
// configurable number of Ncr bytes) and a frame/latency/response model.
module tb_sd_cmd_ctrl;
  import sd_pkg::*;

  localparam int CD  = 4;
  localparam int NCR = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req, wr_req, rd_req;
  logic [5:0]  init_cmd, wr_cmd, rd_cmd;
  logic [31:0] init_arg, wr_arg, rd_arg;
  logic        init_done;
  logic        init_ack, wr_ack, rd_ack;
  logic [39:0] resp;
  logic        resp_to, busy;
  logic        sd_sclk, sd_cs_n, sd_mosi, sd_miso;

  int errors = 0;
  int checks = 0;

  // card configuration (written by the stimulus only)
  int          card_ncr = 1;
  logic [39:0] card_resp = '0;
  bit          card_long = 1'b0;
  bit          card_silent = 1'b0;
  // card observations (written by the card only)
  logic [47:0] rx_frame;
  int          rx_cnt;
  int          mosi_idle_zero = 0;

  always #5 clk = ~clk;

  sd_cmd_ctrl #(.CLK_DIV(CD), .NCR_MAX(NCR)) dut (
    .clk      (clk),
    .rst      (rst),
    .init_req (init_req),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .init_cmd (init_cmd),
    .wr_cmd   (wr_cmd),
    .rd_cmd   (rd_cmd),
    .init_arg (init_arg),
    .wr_arg   (wr_arg),
    .rd_arg   (rd_arg),
    .init_done(init_done),
    .init_ack (init_ack),
    .wr_ack   (wr_ack),
    .rd_ack   (rd_ack),
    .resp     (resp),
    .resp_to  (resp_to),
    .busy     (busy),
    .sd_sclk  (sd_sclk),
    .sd_cs_n  (sd_cs_n),
    .sd_mosi  (sd_mosi),
    .sd_miso  (sd_miso)
  );

  // Behavioural card: samples MOSI on SCLK rise, drives MISO on SCLK fall.
  initial begin
    bit tx_q[$];
    sd_miso  = 1'b1;
    rx_cnt   = 0;
    rx_frame = '0;
    forever begin
      @(posedge sd_sclk or negedge sd_sclk or posedge sd_cs_n);
      if (sd_cs_n !== 1'b0) begin
        rx_cnt  = 0;
        sd_miso = 1'b1;
        tx_q.delete();
      end else if (sd_sclk) begin
        if (rx_cnt < 48) begin
          rx_frame = {rx_frame[46:0], sd_mosi};
          rx_cnt++;
          if (rx_cnt == 48 && !card_silent) begin
            for (int i = 0; i < card_ncr * 8; i++) tx_q.push_back(1'b1);
            for (int i = (card_long ? 39 : 7); i >= 0; i--) tx_q.push_back(card_resp[i]);
          end
        end else if (sd_mosi !== 1'b1) begin
          mosi_idle_zero++;
        end
      end else if (rx_cnt == 48) begin
        sd_miso = (tx_q.size() != 0) ? tx_q.pop_front() : 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_crc_byte(input logic [39:0] head);
`ifdef SD_CRC7_EN
    logic [46:0] rem;
    rem = {head, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    return {rem[6:0], 1'b1};
`else
    if (head[37:32] == CMD0) return 8'h95;
    if (head[37:32] == CMD8) return 8'h87;
    return 8'hFF;
`endif
  endfunction

  // Runs one transaction from the current negedge; lat_adj accounts for a
  // grant that already happened before the call.
  task automatic run_txn(input int who, input logic [5:0] cmd, input logic [31:0] arg,
                         input int ncr, input logic [39:0] cresp, input bit silent,
                         input int lat_adj, input string tag);
    logic [47:0] exp_frame;
    logic [2:0]  exp_ack, acks;
    int          exp_cyc, cyc, zero0;
    bit          lng;
    lng         = (cmd == CMD8) || (cmd == CMD58);
    card_ncr    = ncr;
    card_resp   = cresp;
    card_long   = lng;
    card_silent = silent;
    exp_frame   = {2'b01, cmd, arg, model_crc_byte({2'b01, cmd, arg})};
    if (silent) exp_cyc = (48 + NCR * 8 + 8) * 2 * CD + 2 + lat_adj;
    else        exp_cyc = (48 + ncr * 8 + (lng ? 40 : 8) + 8) * 2 * CD + 2 + lat_adj;
    exp_ack = 3'b100 >> who;
    zero0   = mosi_idle_zero;
    case (who)
      0: begin init_cmd = cmd; init_arg = arg; init_req = 1'b1; end
      1: begin wr_cmd = cmd;   wr_arg = arg;   wr_req = 1'b1;   end
      default: begin rd_cmd = cmd; rd_arg = arg; rd_req = 1'b1; end
    endcase
    cyc  = 0;
    acks = '0;
    while (cyc < 3000 && acks == 3'b000) begin
      @(negedge clk);
      cyc++;
      acks = {init_ack, wr_ack, rd_ack};
    end
    chk({tag, "/latency"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "/ack_sel"}, 64'(acks), 64'(exp_ack));
    chk({tag, "/frame"}, 64'(rx_frame), 64'(exp_frame));
    chk({tag, "/cs_n_at_ack"}, 64'(sd_cs_n), 64'(1));
    chk({tag, "/resp_to"}, 64'(resp_to), 64'(silent));
    if (silent)   chk({tag, "/resp"}, 64'(resp), 64'(40'hFF_FFFF_FFFF));
    else if (lng) chk({tag, "/resp"}, 64'(resp), 64'(cresp));
    else          chk({tag, "/r1"}, 64'(resp[7:0]), 64'(cresp[7:0]));
    case (who)
      0: init_req = 1'b0;
      1: wr_req = 1'b0;
      default: rd_req = 1'b0;
    endcase
    @(negedge clk);
    chk({tag, "/ack_once"}, 64'({init_ack, wr_ack, rd_ack}), 64'(0));
    chk({tag, "/mosi_idle"}, 64'(mosi_idle_zero - zero0), 64'(0));
  endtask

  initial begin
    int          bad;
    logic [63:0] rnd;
    logic [5:0]  cmd_tab [8];
    logic [5:0]  c;
    logic [39:0] cr;
    int          who;

    rst = 1'b1;
    init_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    init_cmd = '0; wr_cmd = '0; rd_cmd = '0;
    init_arg = '0; wr_arg = '0; rd_arg = '0;
    init_done = 1'b0;

    @(negedge clk);
    chk("reset/pins", 64'({sd_sclk, sd_cs_n, sd_mosi, resp_to, busy, init_ack, wr_ack, rd_ack}),
        64'(8'b0110_0000));
    chk("reset/resp", 64'(resp), 64'(40'hFF_FFFF_FFFF));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // read request ignored before init_done
    rd_cmd = CMD17; rd_arg = 32'h0000_0200; rd_req = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sd_cs_n !== 1'b1 || busy !== 1'b0 || rd_ack !== 1'b0) bad++;
    end
    chk("gated_rd/no_grant", 64'(bad), 64'(0));
    rd_req = 1'b0;
    @(negedge clk);

    run_txn(0, CMD0, 32'h0, 1, 40'h01, 1'b0, 0, "cmd0");
    chk("cmd0/crc_byte", 64'(rx_frame[7:0]), 64'(8'h95));
    chk("cmd0/frame_const", 64'(rx_frame), 64'(48'h40_0000_0000_95));

    run_txn(0, CMD8, 32'h0000_01AA, 1, 40'h01_0000_01AA, 1'b0, 0, "cmd8");
    chk("cmd8/crc_byte", 64'(rx_frame[7:0]), 64'(8'h87));
    chk("cmd8/resp_const", 64'(resp), 64'(40'h01_0000_01AA));

    run_txn(0, CMD58, 32'h0, 1, 40'hFF_FFFF_FFFF, 1'b1, 0, "timeout");

    // arbitration: wr and rd raised together, wr first, rd right after
    init_done = 1'b1;
    rd_cmd = CMD17; rd_arg = 32'h0000_1000; rd_req = 1'b1;
    run_txn(1, CMD24, 32'h0000_2000, 1, 40'h00, 1'b0, 0, "arb_wr");
    run_txn(2, CMD17, 32'h0000_1000, 2, 40'h05, 1'b0, -1, "arb_rd");

    // async reset in the middle of SEND
    init_cmd = CMD0; init_arg = 32'h0; init_req = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_mid/in_send", 64'({busy, sd_cs_n}), 64'(2'b10));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid/pins", 64'({sd_cs_n, sd_sclk, sd_mosi, busy}), 64'(4'b1010));
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if ({init_ack, wr_ack, rd_ack} !== 3'b000) bad++;
    end
    chk("rst_mid/no_ack", 64'(bad), 64'(0));
    rst = 1'b0;
    run_txn(0, CMD0, 32'h0, 1, 40'h01, 1'b0, 0, "rst_restart");

`ifdef SD_CRC7_EN
    run_txn(1, CMD55, 32'h0, 1, 40'h01, 1'b0, 0, "crc_cmd55");
    chk("crc_cmd55/byte", 64'(rx_frame[7:0]), 64'(8'h65));
    run_txn(1, ACMD41, 32'h4000_0000, 1, 40'h00, 1'b0, 0, "crc_acmd41");
    chk("crc_acmd41/byte", 64'(rx_frame[7:0]), 64'(8'h77));
`endif

    // randomized transactions
    cmd_tab = '{CMD0, CMD8, CMD17, CMD24, CMD55, ACMD41, CMD58, 6'd0};
    for (int i = 0; i < 8; i++) begin
      who = int'($urandom_range(0, 2));
      c   = (i % 4 == 3) ? 6'($urandom) : cmd_tab[$urandom_range(0, 6)];
      rnd = {$urandom, $urandom};
      if (c == CMD8 || c == CMD58) cr = {1'b0, rnd[38:0]};
      else                         cr = {33'h0, rnd[6:0]};
      run_txn(who, c, $urandom, int'($urandom_range(0, 3)), cr,
              ($urandom_range(0, 5) == 0), 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
